id_gen: RTL and testbench

//  Transmit-side counterpart of the ID checker. Accepts a letter code and NUM_DIGITS body digits

---
 rtl/idg_pkg.sv | 26 ++
 rtl/idg_mod10_mac.sv | 20 ++
 rtl/id_gen.sv | 168 ++++++++++++++++
 tb/tb_id_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idg_pkg.sv
// Shared types, constants and mod-10 arithmetic helpers for the ID generator.
// Build option: IDG_RANGE_CHECK_EN (see id_gen) uses the range limits defined here.
package idg_pkg;

  typedef enum logic {
    COLLECT,
    EMIT
  } state_t;

  localparam int LETTER_MIN         = 10;
  localparam int LETTER_MAX         = 35;
  localparam int DIGIT_MAX          = 9;
  localparam int LETTER_UNIT_WEIGHT = 9;
  localparam int MAC_W              = 16;
  localparam int WGT_W              = 8;

  function automatic logic [3:0] mod10(input logic [MAC_W-1:0] x);
    return 4'(x % MAC_W'(10));
  endfunction

  // Body position k (1..num_digits) carries weight num_digits+1-k.
  function automatic logic [WGT_W-1:0] weight(input int num_digits, input int k);
    return WGT_W'(num_digits + 1 - k);
  endfunction

endpackage

// File: rtl/idg_mod10_mac.sv
// Combinational mod-10 multiply-accumulate: acc_out = (acc_in + (sym % 10) * wgt) % 10.
module idg_mod10_mac
  import idg_pkg::*;
#(
  parameter int SYM_W = 6
) (
  input  logic [3:0]       acc_in,
  input  logic [SYM_W-1:0] sym,
  input  logic [WGT_W-1:0] wgt,
  output logic [3:0]       acc_out
);

  logic [MAC_W-1:0] sum;

  always_comb begin
    sum     = MAC_W'(acc_in) + MAC_W'(mod10(MAC_W'(sym))) * MAC_W'(wgt);
    acc_out = mod10(sum);
  end

endmodule

// File: rtl/id_gen.sv
// ID generator: collects a letter code plus NUM_DIGITS body digits, then emits them followed by a mod-10 check digit.
// Build option: define IDG_RANGE_CHECK_EN to add out_err, flagging out-of-range symbols on the last beat.
module id_gen
  import idg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SYM_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_id,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_id,
  output logic             out_last,
`ifdef IDG_RANGE_CHECK_EN
  output logic             out_err,
`endif
  input  logic             out_ready
);

  localparam int IDX_W = $clog2(NUM_DIGITS + 2);
  localparam logic [IDX_W-1:0] LAST_IN   = IDX_W'(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_DIGITS + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       acc_q, acc_d;
  logic [SYM_W-1:0] buf_q [0:NUM_DIGITS];
  logic [SYM_W-1:0] buf_d [0:NUM_DIGITS];
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_id_q, out_id_d;
  logic             out_last_q, out_last_d;

  logic             in_fire;
  logic [IDX_W-1:0] next_beat;
  logic [SYM_W-1:0] check_sym;
  logic [3:0]       mac0_acc, mac0_out, mac1_out;
  logic [SYM_W-1:0] mac0_sym, mac1_sym;
  logic [WGT_W-1:0] mac0_wgt, mac1_wgt;

  assign in_ready  = (state_q == COLLECT);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

  // The letter needs two MAC terms (tens*1, units*9); body digits use only the first and pass through the second.
  always_comb begin
    if (idx_q == '0) begin
      mac0_acc = '0;
      mac0_sym = in_id / SYM_W'(10);
      mac0_wgt = WGT_W'(1);
      mac1_sym = in_id;
      mac1_wgt = WGT_W'(LETTER_UNIT_WEIGHT);
    end else begin
      mac0_acc = acc_q;
      mac0_sym = in_id;
      mac0_wgt = weight(NUM_DIGITS, int'(idx_q));
      mac1_sym = '0;
      mac1_wgt = '0;
    end
  end

  idg_mod10_mac #(.SYM_W(SYM_W)) u_mac0 (
    .acc_in  (mac0_acc),
    .sym     (mac0_sym),
    .wgt     (mac0_wgt),
    .acc_out (mac0_out)
  );

  idg_mod10_mac #(.SYM_W(SYM_W)) u_mac1 (
    .acc_in  (mac0_out),
    .sym     (mac1_sym),
    .wgt     (mac1_wgt),
    .acc_out (mac1_out)
  );

  assign check_sym = SYM_W'(mod10(MAC_W'(10) - MAC_W'(acc_q)));
  assign next_beat = idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    case (state_q)
      COLLECT: begin
        if (in_fire) begin
          buf_d[idx_q] = in_id;
          acc_d        = mac1_out;
          if (idx_q == LAST_IN) begin
            state_d     = EMIT;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_id_d    = (idx_q == '0) ? in_id : buf_q[0];
            out_last_d  = 1'b0;
          end else begin
            idx_d = next_beat;
          end
        end
      end
      EMIT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = COLLECT;
            idx_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_id_d    = '0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = next_beat;
            out_last_d = (next_beat == LAST_BEAT);
            out_id_d   = (next_beat == LAST_BEAT) ? check_sym : buf_q[next_beat];
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i <= NUM_DIGITS; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      buf_q       <= buf_d;
    end
  end

`ifdef IDG_RANGE_CHECK_EN
  logic err_q, err_d;
  logic sym_bad;

  // Sticky per packet; cleared when the check-digit beat is accepted.
  always_comb begin
    if (idx_q == '0) sym_bad = (int'(in_id) < LETTER_MIN) || (int'(in_id) > LETTER_MAX);
    else             sym_bad = (int'(in_id) > DIGIT_MAX);
    err_d = err_q;
    if (state_q == COLLECT && in_fire && sym_bad) err_d = 1'b1;
    if (state_q == EMIT && out_valid_q && out_ready && out_last_q) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign out_err = err_q && out_last_q;
`endif

endmodule

// File: tb/tb_id_gen.sv
// Self-checking bench for id_gen: random traffic against an arithmetic check-digit model.
`timescale 1ns/1ps
module tb_id_gen;

  localparam int N   = 8;
  localparam int SW  = 6;
  localparam int NIN = N + 1;
  localparam int NB  = N + 2;

  typedef logic [SW-1:0] sym_t;
  typedef sym_t symq_t[$];
  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [SW-1:0] in_id = '0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic [SW-1:0] out_id;
`ifdef IDG_RANGE_CHECK_EN
  logic out_err;
`endif

  int tests = 0;
  int fails = 0;

  id_gen #(.NUM_DIGITS(N), .SYM_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_id     (in_id),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_last  (out_last),
`ifdef IDG_RANGE_CHECK_EN
    .out_err   (out_err),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: weighted sum t + 9u + sum((d%10)*w), check digit brings it to 0 mod 10.
  function automatic int model_check(input symq_t syms);
    int sum;
    sum = (int'(syms[0]) / 10) + 9 * (int'(syms[0]) % 10);
    for (int k = 1; k <= N; k++) sum += (int'(syms[k]) % 10) * (N + 1 - k);
    return (10 - (sum % 10)) % 10;
  endfunction

  function automatic symq_t model_stream(input symq_t syms);
    symq_t s;
    s = syms;
    s.push_back(sym_t'(model_check(syms)));
    return s;
  endfunction

  function automatic bit model_err(input symq_t syms);
    bit e;
    e = (int'(syms[0]) < 10) || (int'(syms[0]) > 35);
    for (int k = 1; k <= N; k++) if (int'(syms[k]) > 9) e = 1'b1;
    return e;
  endfunction

  function automatic bit id_checker_ok(input symq_t s);
    int sum;
    if (s.size() != NB) return 1'b0;
    sum = (int'(s[0]) / 10) + 9 * (int'(s[0]) % 10) + int'(s[NB-1]);
    for (int k = 1; k <= N; k++) sum += (int'(s[k]) % 10) * (N + 1 - k);
    return (sum % 10) == 0;
  endfunction

  function automatic symq_t rand_packet(input bit legal);
    symq_t p;
    p.push_back(legal ? sym_t'($urandom_range(35, 10)) : sym_t'($urandom));
    for (int k = 1; k <= N; k++) p.push_back(legal ? sym_t'($urandom_range(9, 0)) : sym_t'($urandom));
    return p;
  endfunction

  function automatic symq_t seq_packet();
    symq_t p;
    p.push_back(sym_t'(10));
    for (int k = 1; k <= N; k++) p.push_back(sym_t'(k));
    return p;
  endfunction

  // Drives one packet and records what the DUT emits plus handshake-rule violations.
  task automatic run_packet(input symq_t syms, input int gap_pct, input int stall_pct, input bit poke_emit,
                            output symq_t got, output bitq_t gotlast, output int delay,
                            output int hold_err, output int overlap, output int stray,
                            output bit timeout, output bit err_last);
    int sent, cyc, last_acc, first_out;
    bit done, prev_stall, prev_last;
    sym_t prev_id;
    got = {}; gotlast = {};
    sent = 0; cyc = 0; last_acc = -1; first_out = -1; done = 0; prev_stall = 0;
    prev_last = 0; prev_id = '0; hold_err = 0; overlap = 0; stray = 0; err_last = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      if (prev_stall && (out_valid !== 1'b1 || out_id !== prev_id || out_last !== prev_last)) hold_err++;
      if (out_valid === 1'b1 && first_out < 0) first_out = cyc;
      if (out_valid === 1'b1 && in_ready === 1'b1) overlap++;
      if (sent < NIN) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_id    = in_valid ? syms[sent] : sym_t'($urandom);
      end else begin
        in_valid = poke_emit && ($urandom_range(1) == 1);
        in_id    = sym_t'($urandom);
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      if (in_valid && in_ready === 1'b1) begin
        if (sent < NIN) begin
          sent++;
          if (sent == NIN) last_acc = cyc;
        end else begin
          stray++;
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        got.push_back(out_id);
        gotlast.push_back(out_last === 1'b1);
`ifdef IDG_RANGE_CHECK_EN
        if (out_last === 1'b1) err_last = (out_err === 1'b1);
`endif
        if (out_last === 1'b1) done = 1'b1;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_id    = out_id;
      prev_last  = out_last;
      cyc++;
    end
    timeout = !done;
    delay = (last_acc >= 0 && first_out >= 0) ? first_out - last_acc : -1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_id !== '0) begin fails++; $display("[TB] FAIL reset_out_id: got %0d expected 0", out_id); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    symq_t p, exp, got; bitq_t gl;
    int dly, he, ov, st; bit to, el;
    p = seq_packet();
    exp = model_stream(p);
    run_packet(p, 0, 0, 1'b0, got, gl, dly, he, ov, st, to, el);
    tests++; if (to || got.size() != NB) begin fails++; $display("[TB] FAIL basic_len: got %0d beats expected %0d", got.size(), NB); end
    else for (int i = 0; i < NB; i++) begin
      tests++;
      if (got[i] !== exp[i] || gl[i] !== (i == NB-1)) begin
        fails++; $display("[TB] FAIL basic_beat%0d: got %0d/last %b expected %0d/last %b", i, got[i], gl[i], exp[i], i == NB-1);
      end
    end
    tests++; if (exp[NB-1] !== sym_t'(9) || got.size() != NB || got[NB-1] !== sym_t'(9)) begin fails++; $display("[TB] FAIL basic_check: got %0d expected 9", (got.size() == NB) ? int'(got[NB-1]) : -1); end
    tests++; if (dly != 1) begin fails++; $display("[TB] FAIL basic_latency: got %0d expected 1", dly); end
  endtask

  task automatic test_extreme();
    symq_t p, got; bitq_t gl;
    int dly, he, ov, st; bit to, el;
    p = {}; p.push_back(sym_t'(35)); for (int k = 1; k <= N; k++) p.push_back(sym_t'(9));
    run_packet(p, 0, 0, 1'b0, got, gl, dly, he, ov, st, to, el);
    tests++; if (to || got.size() != NB || got[NB-1] !== sym_t'(8)) begin fails++; $display("[TB] FAIL extreme_max_check: got %0d expected 8", (got.size() == NB) ? int'(got[NB-1]) : -1); end
    tests++; if (!id_checker_ok(got)) begin fails++; $display("[TB] FAIL extreme_max_checker: got 0 expected 1"); end
    p = {}; p.push_back(sym_t'(10)); for (int k = 1; k <= N; k++) p.push_back(sym_t'(0));
    run_packet(p, 0, 0, 1'b0, got, gl, dly, he, ov, st, to, el);
    tests++; if (to || got.size() != NB || got[NB-1] !== sym_t'(9)) begin fails++; $display("[TB] FAIL extreme_min_check: got %0d expected 9", (got.size() == NB) ? int'(got[NB-1]) : -1); end
    tests++; if (!id_checker_ok(got)) begin fails++; $display("[TB] FAIL extreme_min_checker: got 0 expected 1"); end
  endtask

  task automatic test_backpressure();
    symq_t p, exp, got; bitq_t gl;
    int dly, he, ov, st; bit to, el;
    for (int n = 0; n < 6; n++) begin
      p = rand_packet(1'b1);
      exp = model_stream(p);
      run_packet(p, 20, 50, 1'b1, got, gl, dly, he, ov, st, to, el);
      tests++; if (to || got != exp) begin fails++; $display("[TB] FAIL bp_stream%0d: got %0d beats last %0d expected check %0d", n, got.size(), (got.size() > 0) ? int'(got[got.size()-1]) : -1, exp[NB-1]); end
      tests++; if (gl.size() != NB || !gl[NB-1] || gl[0]) begin fails++; $display("[TB] FAIL bp_last%0d: got %0d last flags expected 1 on beat %0d", n, gl.size(), NB-1); end
      tests++; if (he != 0) begin fails++; $display("[TB] FAIL bp_hold%0d: got %0d unstable stalls expected 0", n, he); end
      tests++; if (ov != 0 || st != 0) begin fails++; $display("[TB] FAIL bp_in_ready%0d: got overlap %0d stray %0d expected 0", n, ov, st); end
    end
  endtask

  task automatic test_input_gaps();
    symq_t p, exp, got; bitq_t gl;
    int dly, he, ov, st; bit to, el;
    p = seq_packet();
    exp = model_stream(p);
    for (int n = 0; n < 3; n++) begin
      run_packet(p, 50, 0, 1'b1, got, gl, dly, he, ov, st, to, el);
      tests++; if (to || got != exp) begin fails++; $display("[TB] FAIL gaps_stream%0d: got %0d beats expected %0d", n, got.size(), NB); end
      tests++; if (st != 0 || dly != 1) begin fails++; $display("[TB] FAIL gaps_ignore%0d: got stray %0d latency %0d expected 0 and 1", n, st, dly); end
    end
  endtask

  task automatic test_reset_in_emit();
    symq_t p, exp, got, pre; bitq_t gl;
    int dly, he, ov, st, cyc; bit to, el;
    p = rand_packet(1'b1);
    exp = model_stream(p);
    for (int i = 0; i < NIN; i++) begin
      @(negedge clk); in_valid = 1'b1; in_id = p[i];
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    pre = {}; cyc = 0;
    while (pre.size() < 4 && cyc < 100) begin
      if (out_valid === 1'b1) pre.push_back(out_id);
      if (pre.size() < 4) @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    tests++; if (pre.size() != 4 || pre[0] !== exp[0] || pre[3] !== exp[3]) begin fails++; $display("[TB] FAIL rst_emit_prefix: got %0d beats expected 4 matching", pre.size()); end
    out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_emit_state: got valid %b ready %b expected 0 1", out_valid, in_ready); end
    p = rand_packet(1'b1);
    exp = model_stream(p);
    run_packet(p, 10, 30, 1'b0, got, gl, dly, he, ov, st, to, el);
    tests++; if (to || got != exp) begin fails++; $display("[TB] FAIL rst_emit_next: got %0d beats expected check %0d", got.size(), exp[NB-1]); end
  endtask

  task automatic test_range();
    symq_t p, exp, got; bitq_t gl;
    int dly, he, ov, st; bit to, el;
    for (int n = 0; n < 3; n++) begin
      p = seq_packet();
      if (n == 0) p[0] = sym_t'(9);
      if (n == 1) p[3] = sym_t'(12);
      exp = model_stream(p);
      run_packet(p, 0, 20, 1'b0, got, gl, dly, he, ov, st, to, el);
      tests++; if (to || got != exp) begin fails++; $display("[TB] FAIL range_stream%0d: got %0d beats expected check %0d", n, got.size(), exp[NB-1]); end
`ifdef IDG_RANGE_CHECK_EN
      tests++; if (el !== model_err(p)) begin fails++; $display("[TB] FAIL range_err%0d: got %b expected %b", n, el, model_err(p)); end
`else
      tests++; if (!id_checker_ok(got)) begin fails++; $display("[TB] FAIL range_checker%0d: got 0 expected 1", n); end
`endif
    end
    p = rand_packet(1'b0);
    exp = model_stream(p);
    run_packet(p, 10, 10, 1'b0, got, gl, dly, he, ov, st, to, el);
    tests++; if (to || got != exp) begin fails++; $display("[TB] FAIL range_random: got %0d beats expected check %0d", got.size(), exp[NB-1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extreme();
    test_backpressure();
    test_input_gaps();
    test_reset_in_emit();
    test_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
